stack_sequencer: RTL and testbench

Multi-cycle controller that owns the 32-bit stack pointer and sequences every stack access for the pipeline: PUSH, POP, CALL, RET, INT and RTI. It decomposes each operation into 16-bit data-memory word transfers, performs the SP decrement and increment, and holds the pipeline stalled until the operation completes. It sits beside the memory stage and arbitrates the data-memory port for stack traffic.

---
 rtl/stack_sequencer.sv | 155 +++++++++++++++
 tb/tb_stack_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - stack pointer owner sequencing PUSH/POP/CALL/RET/INT/RTI as 16-bit word transfers
module stack_sequencer #(
  parameter logic [31:0] SP_INIT = 32'h000F_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  output logic        op_ready,
  input  logic [15:0] data_in,
  input  logic [31:0] pc_in,
  input  logic [2:0]  flags_in,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        done,
  output logic [15:0] data_out,
  output logic [31:0] pc_out,
  output logic [2:0]  flags_out,
  output logic [31:0] sp_out
);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_INT  = 3'd4;
  localparam logic [2:0] OP_RTI  = 3'd5;

  typedef enum logic [2:0] {IDLE, WR, RD, CAP, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  op;
  logic [1:0]  cnt;
  logic [1:0]  last;
  logic [15:0] d_lat;
  logic [31:0] pc_lat;
  logic [2:0]  f_lat;
  logic [31:0] sp;
  logic [15:0] wword;

  assign sp_out = sp;

  // index of the final word of the latched operation
  always_comb begin
    last = 2'd2;
    case (op)
      OP_PUSH, OP_POP: last = 2'd0;
      OP_CALL, OP_RET: last = 2'd1;
      default:         last = 2'd2;
    endcase
  end

  always_comb begin
    wword = d_lat;
    if (op == OP_CALL || op == OP_INT) begin
      case (cnt)
        2'd0:    wword = pc_lat[31:16];
        2'd1:    wword = pc_lat[15:0];
        default: wword = {13'b0, f_lat};
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_PUSH, OP_CALL, OP_INT: state_nx = WR;
            OP_POP, OP_RET, OP_RTI:   state_nx = RD;
            default:                  state_nx = DONE;
          endcase
        end
      end
      WR:      if (cnt == last) state_nx = DONE;
      RD:      state_nx = CAP;
      CAP:     state_nx = (cnt == last) ? DONE : RD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (state == IDLE);
    stall     = (state != IDLE);
    done      = (state == DONE);
    mem_wr    = (state == WR);
    mem_rd    = (state == RD);
    mem_addr  = 32'd0;
    mem_wdata = 16'd0;
    if (state == WR) begin
      mem_addr  = sp;
      mem_wdata = wword;
    end else if (state == RD) begin
      mem_addr  = sp + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op        <= 3'd0;
      cnt       <= 2'd0;
      d_lat     <= 16'd0;
      pc_lat    <= 32'd0;
      f_lat     <= 3'd0;
      sp        <= SP_INIT;
      data_out  <= 16'd0;
      pc_out    <= 32'd0;
      flags_out <= 3'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (op_valid) begin
            op     <= op_code;
            d_lat  <= data_in;
            pc_lat <= pc_in;
            f_lat  <= flags_in;
            cnt    <= 2'd0;
          end
        end
        WR: begin
          sp  <= sp - 32'd1;
          cnt <= cnt + 2'd1;
        end
        RD: sp <= sp + 32'd1;
        CAP: begin
          cnt <= cnt + 2'd1;
          // pop order mirrors push order reversed: RTI gets flags, PC low, PC high
          case (op)
            OP_POP: data_out <= mem_rdata;
            OP_RET: begin
              if (cnt == 2'd0) pc_out[15:0]  <= mem_rdata;
              else             pc_out[31:16] <= mem_rdata;
            end
            OP_RTI: begin
              if (cnt == 2'd0)      flags_out     <= mem_rdata[2:0];
              else if (cnt == 2'd1) pc_out[15:0]  <= mem_rdata;
              else                  pc_out[31:16] <= mem_rdata;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - self-checking bench: directed table, corner sequences, randomized ops vs stack model
module tb_stack_sequencer;

  localparam logic [31:0] SPI = 32'h000F_FFFF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, op_valid, op_valid0;
  logic [2:0]  op_code, op_code0, flags_in;
  logic [15:0] data_in, mem_rdata;
  logic [31:0] pc_in;
  logic        op_ready, mem_wr, mem_rd, stall, done;
  logic [31:0] mem_addr, pc_out, sp_out;
  logic [15:0] mem_wdata, data_out;
  logic [2:0]  flags_out;
  logic        op_ready0, mem_wr0, mem_rd0, stall0, done0;
  logic [31:0] mem_addr0, pc_out0, sp_out0;
  logic [15:0] mem_wdata0, data_out0;
  logic [2:0]  flags_out0;
  logic [15:0] mem_rdata0 = 16'h3C3C;

  stack_sequencer dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .data_in(data_in), .pc_in(pc_in), .flags_in(flags_in), .mem_addr(mem_addr),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall(stall), .done(done), .data_out(data_out), .pc_out(pc_out),
    .flags_out(flags_out), .sp_out(sp_out));

  stack_sequencer #(.SP_INIT(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset), .op_valid(op_valid0), .op_code(op_code0), .op_ready(op_ready0),
    .data_in(data_in), .pc_in(pc_in), .flags_in(flags_in), .mem_addr(mem_addr0),
    .mem_wr(mem_wr0), .mem_rd(mem_rd0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
    .stall(stall0), .done(done0), .data_out(data_out0), .pc_out(pc_out0),
    .flags_out(flags_out0), .sp_out(sp_out0));

  // data memory fixture: read data appears the cycle after mem_rd
  logic [15:0] mem [logic [31:0]];
  initial mem_rdata = 16'h0;
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] = mem_wdata;
    if (mem_rd) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 16'h0;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  // behavioural stack model
  logic [15:0] m_mem [logic [31:0]];
  logic [31:0] m_sp = SPI;
  logic [15:0] m_data = 16'h0;
  logic [31:0] m_pc = 32'h0;
  logic [2:0]  m_flags = 3'h0;
  int          m_cyc;

  task automatic m_push(input logic [15:0] w);
    exp_q.push_back('{1'b1, m_sp, w});
    m_mem[m_sp] = w;
    m_sp = m_sp - 32'd1;
  endtask

  task automatic m_pop(output logic [15:0] w);
    m_sp = m_sp + 32'd1;
    exp_q.push_back('{1'b0, m_sp, 16'h0});
    w = m_mem.exists(m_sp) ? m_mem[m_sp] : 16'h0;
  endtask

  task automatic model_op(input logic [2:0] op, input logic [15:0] d, input logic [31:0] pc,
                          input logic [2:0] f);
    logic [15:0] w, lo, hi;
    exp_q.delete();
    case (op)
      3'd0: m_push(d);
      3'd2: begin m_push(pc[31:16]); m_push(pc[15:0]); end
      3'd4: begin m_push(pc[31:16]); m_push(pc[15:0]); m_push({13'b0, f}); end
      3'd1: begin m_pop(w); m_data = w; end
      3'd3: begin m_pop(lo); m_pop(hi); m_pc = {hi, lo}; end
      3'd5: begin m_pop(w); m_flags = w[2:0]; m_pop(lo); m_pop(hi); m_pc = {hi, lo}; end
      default: ;
    endcase
    m_cyc = 1;
    foreach (exp_q[i]) m_cyc += exp_q[i].wr ? 1 : 2;
  endtask

  // issue one op from an idle #1-after-edge point; returns cycles until done
  task automatic run_op(input logic [2:0] op, input logic [15:0] d, input logic [31:0] pc,
                        input logic [2:0] f, input logic busy_valid, output int cyc);
    op_valid = 1'b1; op_code = op; data_in = d; pc_in = pc; flags_in = f;
    @(posedge clk); #1;
    op_valid = busy_valid;
    op_code  = 3'($urandom_range(0, 7));
    data_in  = 16'($urandom);
    pc_in    = $urandom;
    flags_in = 3'($urandom);
    obs_q.delete();
    cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      if (mem_wr) obs_q.push_back('{1'b1, mem_addr, mem_wdata});
      if (mem_rd) obs_q.push_back('{1'b0, mem_addr, 16'h0});
      if (mem_wr && mem_rd) check("strobe_overlap", 1, 0);
      if (done) begin cyc = c; break; end
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    if (cyc == 0) check("done_timeout", 0, 1);
    @(posedge clk); #1;
    check("ready_after_done", op_ready, 1);
    check("stall_after_done", stall, 0);
  endtask

  task automatic compare_events();
    check("ev_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check("ev_kind", obs_q[i].wr, exp_q[i].wr);
      check("ev_addr", obs_q[i].addr, exp_q[i].addr);
      check("ev_wdata", obs_q[i].data, exp_q[i].data);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] d;
    logic [31:0] pc;
    logic [2:0]  f;
    int          cyc;
    int          n_ev;
    logic [31:0] first_addr;
    logic [31:0] sp;
    logic [15:0] dout;
    logic [31:0] pout;
    logic [2:0]  fout;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cyc;
    vecs[0] = '{3'd0, 16'hA5A5, 32'h0,          3'd0,   2, 1, 32'h000F_FFFF, 32'h000F_FFFE, 16'h0,    32'h0,          3'd0};
    vecs[1] = '{3'd1, 16'h0,    32'h0,          3'd0,   3, 1, 32'h000F_FFFF, 32'h000F_FFFF, 16'hA5A5, 32'h0,          3'd0};
    vecs[2] = '{3'd2, 16'h0,    32'h1234_5678,  3'd0,   3, 2, 32'h000F_FFFF, 32'h000F_FFFD, 16'hA5A5, 32'h0,          3'd0};
    vecs[3] = '{3'd3, 16'h0,    32'h0,          3'd0,   5, 2, 32'h000F_FFFE, 32'h000F_FFFF, 16'hA5A5, 32'h1234_5678,  3'd0};
    vecs[4] = '{3'd4, 16'h0,    32'h0000_0020,  3'b101, 4, 3, 32'h000F_FFFF, 32'h000F_FFFC, 16'hA5A5, 32'h1234_5678,  3'd0};
    vecs[5] = '{3'd5, 16'h0,    32'h0,          3'd0,   7, 3, 32'h000F_FFFD, 32'h000F_FFFF, 16'hA5A5, 32'h0000_0020,  3'b101};
    vecs[6] = '{3'd6, 16'h7777, 32'hFFFF_0000,  3'd7,   1, 0, 32'h0,         32'h000F_FFFF, 16'hA5A5, 32'h0000_0020,  3'b101};

    reset = 1'b0; op_valid = 1'b0; op_code = 3'd0; data_in = 16'h0; pc_in = 32'h0; flags_in = 3'h0;
    op_valid0 = 1'b0; op_code0 = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_op_ready", op_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_data_out", data_out, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_flags_out", flags_out, 0);
    check("rst_sp", sp_out, SPI);
    check("rst_sp0", sp_out0, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      model_op(vecs[i].op, vecs[i].d, vecs[i].pc, vecs[i].f);
      run_op(vecs[i].op, vecs[i].d, vecs[i].pc, vecs[i].f, 1'b0, cyc);
      check($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
      check($sformatf("vec%0d_nev", i), obs_q.size(), vecs[i].n_ev);
      if (obs_q.size() > 0) check($sformatf("vec%0d_addr0", i), obs_q[0].addr, vecs[i].first_addr);
      check($sformatf("vec%0d_sp", i), sp_out, vecs[i].sp);
      check($sformatf("vec%0d_data_out", i), data_out, vecs[i].dout);
      check($sformatf("vec%0d_pc_out", i), pc_out, vecs[i].pout);
      check($sformatf("vec%0d_flags_out", i), flags_out, vecs[i].fout);
      compare_events();
    end

    // wrap-around on the SP_INIT=0 instance
    op_valid0 = 1'b1; op_code0 = 3'd0; data_in = 16'h1111;
    @(posedge clk); #1;
    op_valid0 = 1'b0;
    check("wrap_push_wr", mem_wr0, 1);
    check("wrap_push_addr", mem_addr0, 32'h0);
    @(posedge clk); #1;
    check("wrap_push_done", done0, 1);
    check("wrap_push_sp", sp_out0, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    op_valid0 = 1'b1; op_code0 = 3'd1;
    @(posedge clk); #1;
    op_valid0 = 1'b0;
    check("wrap_pop_rd", mem_rd0, 1);
    check("wrap_pop_addr", mem_addr0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wrap_pop_done", done0, 1);
    check("wrap_pop_sp", sp_out0, 32'h0);
    check("wrap_pop_data", data_out0, 16'h3C3C);
    @(posedge clk); #1;

    // reset during the second WR cycle of INT, with op_valid held while busy
    op_valid = 1'b1; op_code = 3'd4; pc_in = 32'hBEEF_0042; flags_in = 3'b011;
    @(posedge clk); #1;
    op_code = 3'd0;
    check("int_wr1_addr", mem_addr, SPI);
    check("int_wr1_data", mem_wdata, 16'hBEEF);
    @(posedge clk); #1;
    check("int_wr2_wr", mem_wr, 1);
    check("int_wr2_addr", mem_addr, SPI - 32'd1);
    reset = 1'b0;
    #1;
    check("abort_mem_wr", mem_wr, 0);
    check("abort_mem_rd", mem_rd, 0);
    check("abort_sp", sp_out, SPI);
    check("abort_ready", op_ready, 1);
    check("abort_pc_out", pc_out, 0);
    op_valid = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("post_abort_stall", stall, 0);
    check("post_abort_sp", sp_out, SPI);
    m_sp = SPI; m_mem[SPI] = 16'hBEEF; m_data = 16'h0; m_pc = 32'h0; m_flags = 3'h0;

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  op;
      logic [15:0] d;
      logic [31:0] pc;
      logic [2:0]  f;
      op = 3'($urandom_range(0, 7));
      d  = 16'($urandom);
      pc = $urandom;
      f  = 3'($urandom);
      model_op(op, d, pc, f);
      run_op(op, d, pc, f, 1'($urandom), cyc);
      check("rnd_cycles", cyc, m_cyc);
      check("rnd_sp", sp_out, m_sp);
      check("rnd_data_out", data_out, m_data);
      check("rnd_pc_out", pc_out, m_pc);
      check("rnd_flags_out", flags_out, m_flags);
      compare_events();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
